// File: rtl/trellis_table_builder_pkg.sv
// rtl/trellis_table_builder_pkg.sv - shared trellis-table constants, o_mux field offsets and FSM states
package trellis_table_builder_pkg;

   localparam int MAX_STATE_REG_NUM = 8;
   localparam int DECODE_BIT_NUM    = 2;
   localparam int MAX_CODE_RATE     = 3;
   localparam int RADIX             = 4;

   localparam logic DECODE_MODE = 1'b1;

   // Encoder o_mux layout: {pair, state, second, first}
   localparam int MUX_PAIR_LSB   = 14;
   localparam int MUX_STATE_LSB  = 6;
   localparam int MUX_SECOND_LSB = 3;
   localparam int MUX_FIRST_LSB  = 0;

   typedef enum logic [1:0] {
      TT_IDLE = 2'd0,
      TT_FILL = 2'd1,
      TT_DONE = 2'd2,
      TT_ERR  = 2'd3
   } tt_state_t;

endpackage

// File: rtl/trellis_table_builder_ram.sv
// rtl/trellis_table_builder_ram.sv - trellis table array, synchronous write, registered read
module trellis_ram #(
   parameter int ADDR_BITS = 8,
   parameter int DATA_BITS = 24
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_we,
   input  logic [ADDR_BITS-1:0] i_waddr,
   input  logic [DATA_BITS-1:0] i_wdata,
   input  logic                 i_re,
   input  logic [ADDR_BITS-1:0] i_raddr,
   output logic [DATA_BITS-1:0] o_rdata
);

   logic [DATA_BITS-1:0] mem [2**ADDR_BITS];
   logic [DATA_BITS-1:0] rdata_q;
   logic [DATA_BITS-1:0] rdata_d;

   // Array itself carries no reset so it can live in block RAM.
   always_ff @(posedge clk) begin
      if (i_we) begin
         mem[i_waddr] <= i_wdata;
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      if (i_re) begin
         rdata_d = mem[i_raddr];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign o_rdata = rdata_q;

endmodule

// File: rtl/trellis_table_builder.sv
// rtl/trellis_table_builder.sv - captures the encoder decode-mode sweep into a radix-4 branch table
module trellis_table_builder
   import trellis_table_builder_pkg::*;
#(
   parameter  int STATE_BITS = MAX_STATE_REG_NUM,
   parameter  int PAIR_BITS  = DECODE_BIT_NUM,
   parameter  int RATE       = MAX_CODE_RATE,
   localparam int BR_BITS    = 2 * RATE,
   localparam int WORD_BITS  = RADIX * BR_BITS,
   localparam int CNT_BITS   = STATE_BITS + PAIR_BITS,
   localparam int MUX_BITS   = CNT_BITS + BR_BITS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_start,
   output logic                  o_en_ce,
   output logic                  o_mode_sel,
   input  logic [MUX_BITS-1:0]   i_mux,
   input  logic                  i_rd_en,
   input  logic [STATE_BITS-1:0] i_rd_state,
   output logic [WORD_BITS-1:0]  o_rd_data,
   output logic                  o_rd_valid,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_seq_err
);

   localparam int STAGE_BITS = (RADIX - 1) * BR_BITS;

   tt_state_t               state_q, state_d;
   logic                    en_ce_q, en_ce_d;
   logic                    done_q, done_d;
   logic                    seq_err_q, seq_err_d;
   logic                    rd_valid_q, rd_valid_d;
   logic [CNT_BITS-1:0]     cnt_q, cnt_d;
   logic [STAGE_BITS-1:0]   stage_q, stage_d;

   logic [PAIR_BITS-1:0]    ent_pair;
   logic [STATE_BITS-1:0]   ent_state;
   logic [BR_BITS-1:0]      ent_branch;
   logic                    idx_ok;
   logic                    ram_we;
   logic                    ram_re;

   always_comb begin
      ent_pair   = i_mux[MUX_PAIR_LSB +: PAIR_BITS];
      ent_state  = i_mux[MUX_STATE_LSB +: STATE_BITS];
      ent_branch = {i_mux[MUX_SECOND_LSB +: RATE], i_mux[MUX_FIRST_LSB +: RATE]};
      idx_ok     = ({ent_state, ent_pair} == cnt_q);
   end

   always_comb begin
      state_d    = state_q;
      en_ce_d    = en_ce_q;
      done_d     = done_q;
      seq_err_d  = seq_err_q;
      rd_valid_d = 1'b0;
      cnt_d      = cnt_q;
      stage_d    = stage_q;
      ram_we     = 1'b0;
      ram_re     = 1'b0;

      case (state_q)
         TT_IDLE: begin
            if (i_start) begin
               state_d = TT_FILL;
               en_ce_d = 1'b1;
            end
         end
         TT_FILL: begin
            if (en_ce_q) begin
               if (!idx_ok) begin
                  // Out-of-order entry is dropped and the sweep is abandoned.
                  state_d   = TT_ERR;
                  en_ce_d   = 1'b0;
                  seq_err_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
                  if (ent_pair == PAIR_BITS'(RADIX - 1)) begin
                     ram_we = 1'b1;
                  end else begin
                     for (int s = 0; s < RADIX - 1; s++) begin
                        if (ent_pair == PAIR_BITS'(s)) begin
                           stage_d[s*BR_BITS +: BR_BITS] = ent_branch;
                        end
                     end
                  end
                  if (cnt_q == {CNT_BITS{1'b1}}) begin
                     state_d = TT_DONE;
                     en_ce_d = 1'b0;
                     done_d  = 1'b1;
                  end
               end
            end
         end
         TT_DONE: begin
            ram_re     = i_rd_en;
            rd_valid_d = i_rd_en;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= TT_IDLE;
         en_ce_q    <= 1'b0;
         done_q     <= 1'b0;
         seq_err_q  <= 1'b0;
         rd_valid_q <= 1'b0;
         cnt_q      <= '0;
         stage_q    <= '0;
      end else begin
         state_q    <= state_d;
         en_ce_q    <= en_ce_d;
         done_q     <= done_d;
         seq_err_q  <= seq_err_d;
         rd_valid_q <= rd_valid_d;
         cnt_q      <= cnt_d;
         stage_q    <= stage_d;
      end
   end

   trellis_ram #(
      .ADDR_BITS (STATE_BITS),
      .DATA_BITS (WORD_BITS)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .i_we    (ram_we),
      .i_waddr (ent_state),
      .i_wdata ({ent_branch, stage_q}),
      .i_re    (ram_re),
      .i_raddr (i_rd_state),
      .o_rdata (o_rd_data)
   );

   assign o_en_ce    = en_ce_q;
   assign o_mode_sel = DECODE_MODE;
   assign o_rd_valid = rd_valid_q;
   assign o_busy     = (state_q == TT_FILL);
   assign o_done     = done_q;
   assign o_seq_err  = seq_err_q;

endmodule

// File: tb/tb_trellis_table_builder.sv
// tb/tb_trellis_table_builder.sv - randomized self-checking bench with a behavioural sweep encoder
module tb_trellis_table_builder;

   logic        clk;
   logic        rst;
   logic        i_start;
   logic        o_en_ce;
   logic        o_mode_sel;
   logic [15:0] i_mux;
   logic        i_rd_en;
   logic [7:0]  i_rd_state;
   logic [23:0] o_rd_data;
   logic        o_rd_valid;
   logic        o_busy;
   logic        o_done;
   logic        o_seq_err;

   int n_tests = 0;
   int n_fail  = 0;

   logic [26:0] gpoly;
   logic        skip_mode;
   logic [9:0]  enc_cnt;
   logic [9:0]  enc_idx;

   logic [7:0]  rd_sts[$];
   logic [23:0] rd_exp[$];
   logic [23:0] last_exp;

   trellis_table_builder dut (
      .clk        (clk),
      .rst        (rst),
      .i_start    (i_start),
      .o_en_ce    (o_en_ce),
      .o_mode_sel (o_mode_sel),
      .i_mux      (i_mux),
      .i_rd_en    (i_rd_en),
      .i_rd_state (i_rd_state),
      .o_rd_data  (o_rd_data),
      .o_rd_valid (o_rd_valid),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_seq_err  (o_seq_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Rate-1/3 shift-register encoder, two input bits per step: pair[0] first, pair[1] second.
   function automatic logic [5:0] enc_branch(input logic [7:0] st, input logic [1:0] pr,
                                             input logic [26:0] g);
      logic [8:0] r1;
      logic [8:0] r2;
      logic [2:0] f;
      logic [2:0] s;
      r1 = {st, pr[0]};
      r2 = {st[6:0], pr[0], pr[1]};
      for (int j = 0; j < 3; j++) begin
         f[j] = ^(g[9*j +: 9] & r1);
         s[j] = ^(g[9*j +: 9] & r2);
      end
      return {s, f};
   endfunction

   function automatic logic [23:0] exp_word(input logic [7:0] st, input logic [26:0] g);
      logic [23:0] w;
      for (int p = 0; p < 4; p++) begin
         w[6*p +: 6] = enc_branch(st, 2'(p), g);
      end
      return w;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) enc_cnt <= '0;
      else if (o_en_ce && enc_cnt != 10'h3ff) enc_cnt <= enc_cnt + 10'd1;
   end

   assign enc_idx = (skip_mode && enc_cnt >= 10'd5) ? enc_cnt + 10'd1 : enc_cnt;
   assign i_mux   = {enc_idx[1:0], enc_idx[9:2], enc_branch(enc_idx[9:2], enc_idx[1:0], gpoly)};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      i_start = 1'b0;
      i_rd_en = 1'b0;
      i_rd_state = '0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic pulse_start();
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
   endtask

   task automatic run_fill(input int spurious_at, output int high);
      high = 0;
      while (o_en_ce && high < 2000) begin
         high++;
         i_start = (high == spurious_at);
         @(negedge clk);
      end
      i_start = 1'b0;
   endtask

   task automatic read_burst();
      for (int i = 0; i < rd_sts.size(); i++) begin
         i_rd_en = 1'b1;
         i_rd_state = rd_sts[i];
         @(negedge clk);
         chk("burst_valid", 32'(o_rd_valid), 32'd1);
         chk("burst_data", 32'(o_rd_data), 32'(rd_exp[i]));
         last_exp = rd_exp[i];
      end
      i_rd_en = 1'b0;
      @(negedge clk);
      chk("burst_valid_end", 32'(o_rd_valid), 32'd0);
      chk("burst_data_hold", 32'(o_rd_data), 32'(last_exp));
   endtask

   initial begin
      int high;
      int bound;
      int en;
      logic [7:0] st;
      logic [7:0] perm[256];
      logic [7:0] tmp;
      int j;

      rst = 1'b0;
      gpoly = {9'h000, 9'h000, 9'h001};
      skip_mode = 1'b0;
      last_exp = '0;

      // Reset values and reads ignored in IDLE
      do_reset();
      chk("rst_en_ce", 32'(o_en_ce), 32'd0);
      chk("rst_done", 32'(o_done), 32'd0);
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_seq_err", 32'(o_seq_err), 32'd0);
      chk("rst_rd_valid", 32'(o_rd_valid), 32'd0);
      chk("rst_rd_data", 32'(o_rd_data), 32'd0);
      chk("rst_mode_sel", 32'(o_mode_sel), 32'd1);
      i_rd_en = 1'b1;
      i_rd_state = 8'd3;
      @(negedge clk);
      i_rd_en = 1'b0;
      chk("idle_rd_valid", 32'(o_rd_valid), 32'd0);

      // Full build with identity-tap polynomial
      pulse_start();
      chk("fill_busy", 32'(o_busy), 32'd1);
      run_fill(0, high);
      chk("fill_en_cycles", 32'(high), 32'd1024);
      chk("fill_done", 32'(o_done), 32'd1);
      chk("fill_busy_end", 32'(o_busy), 32'd0);
      chk("enc_saw_1024", 32'(enc_cnt), 32'h3ff);
      rd_sts = '{8'd0, 8'd1, 8'd128, 8'd255};
      rd_exp = '{24'h248040, 24'h248040, 24'h248040, 24'h248040};
      read_burst();

      // Reset mid-fill with K=9 polynomials
      gpoly = {9'o000, 9'o753, 9'o561};
      do_reset();
      pulse_start();
      bound = 0;
      while (enc_cnt != 10'd500 && bound < 2000) begin
         bound++;
         @(negedge clk);
      end
      chk("reach_cnt500", 32'(enc_cnt), 32'd500);
      rst = 1'b0;
      #1;
      chk("midrst_outs", 32'({o_en_ce, o_busy, o_done, o_seq_err, o_rd_valid}), 32'd0);
      chk("midrst_rd_data", 32'(o_rd_data), 32'd0);
      chk("midrst_mode_sel", 32'(o_mode_sel), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_idle_en", 32'(o_en_ce), 32'd0);

      // Rebuild with a spurious start in FILL, then one in DONE
      pulse_start();
      run_fill(400, high);
      chk("rebuild_en_cycles", 32'(high), 32'd1024);
      chk("rebuild_done", 32'(o_done), 32'd1);
      pulse_start();
      chk("done_start_en", 32'(o_en_ce), 32'd0);
      chk("done_start_done", 32'(o_done), 32'd1);
      chk("done_start_busy", 32'(o_busy), 32'd0);

      for (int i = 0; i < 256; i++) perm[i] = 8'(i);
      for (int i = 255; i > 0; i--) begin
         j = $urandom_range(i, 0);
         tmp = perm[i];
         perm[i] = perm[j];
         perm[j] = tmp;
      end
      rd_sts = {};
      rd_exp = {};
      for (int i = 0; i < 256; i++) begin
         rd_sts.push_back(perm[i]);
         rd_exp.push_back(exp_word(perm[i], gpoly));
      end
      read_burst();

      // Random reads with gaps; data holds while idle
      for (int k = 0; k < 60; k++) begin
         en = $urandom_range(1, 0);
         st = 8'($urandom);
         i_rd_en = en[0];
         i_rd_state = st;
         @(negedge clk);
         chk("rand_valid", 32'(o_rd_valid), 32'(en));
         if (en != 0) last_exp = exp_word(st, gpoly);
         chk("rand_data", 32'(o_rd_data), 32'(last_exp));
      end
      i_rd_en = 1'b0;

      // Ordering error: indices 0..4 then 6
      skip_mode = 1'b1;
      do_reset();
      pulse_start();
      bound = 0;
      while (enc_cnt != 10'd5 && bound < 100) begin
         bound++;
         @(negedge clk);
      end
      chk("err_reach5", 32'(enc_cnt), 32'd5);
      chk("err_before", 32'(o_seq_err), 32'd0);
      @(negedge clk);
      chk("err_seq_err", 32'(o_seq_err), 32'd1);
      chk("err_en_ce", 32'(o_en_ce), 32'd0);
      chk("err_done", 32'(o_done), 32'd0);
      chk("err_busy", 32'(o_busy), 32'd0);
      i_rd_en = 1'b1;
      i_rd_state = 8'd0;
      @(negedge clk);
      i_rd_en = 1'b0;
      chk("err_rd_valid", 32'(o_rd_valid), 32'd0);
      pulse_start();
      @(negedge clk);
      chk("err_start_en", 32'(o_en_ce), 32'd0);
      chk("err_start_sticky", 32'(o_seq_err), 32'd1);
      chk("err_start_done", 32'(o_done), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
